dram_cycle_arbiter: RTL and testbench

- Sequences the fast-RAM DRAM array and shares it between CPU accesses and CAS-before-RAS refresh.
- Drives the RAS/CAS/mux/OE strobes and the RAM acknowledge from decoded CPU access requests.
- Sits between the address decode and the DRAM pins.
- Refresh has priority at idle but never interrupts a CPU cycle in progress.

---
 rtl/dram_cycle_arbiter.sv | 212 +++++++++++++++++++++
 tb/tb_dram_cycle_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dram_cycle_arbiter.sv
// Fast-RAM DRAM sequencer: shares the array between CPU accesses and CAS-before-RAS
// refresh, driving registered RAS/CAS/mux/OE strobes and the RAM acknowledge.
module dram_cycle_arbiter #(
  parameter int REFRESH_INTERVAL = 430,
  parameter int PRECHARGE_CYCLES = 2,
  parameter int REF_RAS_CYCLES   = 3,
  parameter int BACKLOG_MAX      = 3
) (
  input  logic       CLKCPU,
  input  logic       RESET,
  input  logic       AS20,
  input  logic       RW20,
  input  logic       RAM_SEL,
  input  logic       BANK,
  input  logic [3:0] LANE_EN,
  output logic [1:0] RAS,
  output logic [3:0] CAS,
  output logic       RAM_MUX,
  output logic       RAMOE,
  output logic       RAM_ACK,
  output logic       REF_BUSY,
  output logic       REF_OVERRUN
);

  localparam int TMR_W    = $clog2(REFRESH_INTERVAL + 1);
  localparam int CNT_MAXV = (PRECHARGE_CYCLES > REF_RAS_CYCLES) ? PRECHARGE_CYCLES : REF_RAS_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAXV + 1);
  localparam int BL_W     = $clog2(BACKLOG_MAX + 1);

  localparam logic [TMR_W-1:0] TMR_RELOAD = TMR_W'(REFRESH_INTERVAL - 1);
  localparam logic [TMR_W-1:0] TMR_ONE    = TMR_W'(1);
  localparam logic [CNT_W-1:0] PRE_LAST   = CNT_W'(PRECHARGE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RAS_LAST   = CNT_W'(REF_RAS_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [BL_W-1:0]  BL_MAX     = BL_W'(BACKLOG_MAX);
  localparam logic [BL_W-1:0]  BL_ONE     = BL_W'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_ROW     = 3'd1;
  localparam logic [2:0] S_COL     = 3'd2;
  localparam logic [2:0] S_STROBE  = 3'd3;
  localparam logic [2:0] S_REF_CAS = 3'd4;
  localparam logic [2:0] S_REF_RAS = 3'd5;
  localparam logic [2:0] S_PRE     = 3'd6;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [TMR_W-1:0] r_timer;
  logic [BL_W-1:0]  r_backlog;
  logic             r_bank;
  logic [3:0]       r_lanes;
  logic             r_read;
  logic             r_refPre;
  logic [1:0]       r_ras;
  logic [3:0]       r_cas;
  logic             r_mux;
  logic             r_oe;
  logic             r_ack;
  logic             r_busy;
  logic             r_overrun;

  logic [2:0]       w_stateNext;
  logic [CNT_W-1:0] w_cntNext;
  logic             w_startCpu;
  logic             w_startRef;
  logic             w_tick;
  logic             w_full;
  logic [BL_W-1:0]  w_backlogNext;
  logic [1:0]       w_ras;
  logic [3:0]       w_cas;
  logic             w_mux;
  logic             w_oe;
  logic             w_ack;
  logic             w_busy;

  // Pending refresh always wins at idle; a running CPU cycle is only ever ended by AS20.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    w_startCpu  = 1'b0;
    w_startRef  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (r_backlog != '0) begin
          w_stateNext = S_REF_CAS;
          w_startRef  = 1'b1;
        end else if (!AS20 && !RAM_SEL) begin
          w_stateNext = S_ROW;
          w_startCpu  = 1'b1;
        end
      end
      S_ROW, S_COL, S_STROBE: begin
        if (AS20) begin
          w_stateNext = S_PRE;
          w_cntNext   = PRE_LAST;
        end else if (r_state == S_ROW) begin
          w_stateNext = S_COL;
        end else begin
          w_stateNext = S_STROBE;
        end
      end
      S_REF_CAS: begin
        w_stateNext = S_REF_RAS;
        w_cntNext   = RAS_LAST;
      end
      S_REF_RAS: begin
        if (r_cnt == '0) begin
          w_stateNext = S_PRE;
          w_cntNext   = PRE_LAST;
        end else begin
          w_cntNext = r_cnt - CNT_ONE;
        end
      end
      S_PRE: begin
        if (r_cnt == '0) w_stateNext = S_IDLE;
        else             w_cntNext   = r_cnt - CNT_ONE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  assign w_tick = (r_timer == '0);
  assign w_full = (r_backlog == BL_MAX);

  always_comb begin
    w_backlogNext = r_backlog;
    if (w_tick && !w_full) w_backlogNext = w_backlogNext + BL_ONE;
    if (w_startRef)        w_backlogNext = w_backlogNext - BL_ONE;
  end

  // Strobes are decoded from the state being left, so each output lags its state by one edge.
  always_comb begin
    w_ras  = 2'b11;
    w_cas  = 4'b1111;
    w_mux  = 1'b1;
    w_oe   = 1'b1;
    w_ack  = 1'b1;
    w_busy = 1'b0;
    case (r_state)
      S_ROW: w_ras[r_bank] = 1'b0;
      S_COL: begin
        w_ras[r_bank] = 1'b0;
        w_mux         = 1'b0;
      end
      S_STROBE: begin
        w_ras[r_bank] = 1'b0;
        w_mux         = 1'b0;
        w_cas         = ~r_lanes;
        w_ack         = 1'b0;
        w_oe          = ~r_read;
      end
      S_REF_CAS: begin
        w_cas  = 4'b0000;
        w_busy = 1'b1;
      end
      S_REF_RAS: begin
        w_ras  = 2'b00;
        w_cas  = 4'b0000;
        w_busy = 1'b1;
      end
      S_PRE:   w_busy = r_refPre;
      default: w_busy = 1'b0;
    endcase
  end

  always_ff @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_timer   <= TMR_RELOAD;
      r_backlog <= '0;
      r_bank    <= 1'b0;
      r_lanes   <= 4'b0000;
      r_read    <= 1'b1;
      r_refPre  <= 1'b0;
      r_ras     <= 2'b11;
      r_cas     <= 4'b1111;
      r_mux     <= 1'b1;
      r_oe      <= 1'b1;
      r_ack     <= 1'b1;
      r_busy    <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_stateNext;
      r_cnt     <= w_cntNext;
      r_timer   <= w_tick ? TMR_RELOAD : (r_timer - TMR_ONE);
      r_backlog <= w_backlogNext;
      r_overrun <= r_overrun | (w_tick && w_full);
      if (w_startCpu) begin
        r_bank  <= BANK;
        r_lanes <= LANE_EN;
        r_read  <= RW20;
      end
      if (r_state != S_PRE) r_refPre <= (r_state == S_REF_RAS);
      r_ras  <= w_ras;
      r_cas  <= w_cas;
      r_mux  <= w_mux;
      r_oe   <= w_oe;
      r_ack  <= w_ack;
      r_busy <= w_busy;
    end
  end

  assign RAS         = r_ras;
  assign CAS         = r_cas;
  assign RAM_MUX     = r_mux;
  assign RAMOE       = r_oe;
  assign RAM_ACK     = r_ack;
  assign REF_BUSY    = r_busy;
  assign REF_OVERRUN = r_overrun;

endmodule

// File: tb/tb_dram_cycle_arbiter.sv
// Self-checking bench for dram_cycle_arbiter: directed scenarios with literal expectations,
// then random CPU traffic compared every cycle against a sequence-level reference model.
module tb_dram_cycle_arbiter;

  localparam int RI = 20;
  localparam int PC = 2;
  localparam int RR = 3;
  localparam int BM = 3;

  localparam int K_IDLE = 0;
  localparam int K_CPU  = 1;
  localparam int K_REF  = 2;
  localparam int K_PRE  = 3;

  logic       CLKCPU  = 1'b0;
  logic       RESET   = 1'b0;
  logic       AS20    = 1'b1;
  logic       RW20    = 1'b1;
  logic       RAM_SEL = 1'b1;
  logic       BANK    = 1'b0;
  logic [3:0] LANE_EN = 4'h0;
  logic [1:0] RAS;
  logic [3:0] CAS;
  logic       RAM_MUX;
  logic       RAMOE;
  logic       RAM_ACK;
  logic       REF_BUSY;
  logic       REF_OVERRUN;

  int nCompared   = 0;
  int nMismatched = 0;

  // Reference model: which sequence is running and how far into it we are.
  int         mEdges;
  int         mBacklog;
  int         mKind;
  int         mStep;
  bit         mOverrun;
  bit         mPreRef;
  bit         mBank;
  bit         mRead;
  logic [3:0] mLanes;
  logic [1:0] eRas;
  logic [3:0] eCas;
  logic       eMux;
  logic       eOe;
  logic       eAck;
  logic       eBusy;

  dram_cycle_arbiter #(
    .REFRESH_INTERVAL(RI),
    .PRECHARGE_CYCLES(PC),
    .REF_RAS_CYCLES  (RR),
    .BACKLOG_MAX     (BM)
  ) dut (
    .CLKCPU     (CLKCPU),
    .RESET      (RESET),
    .AS20       (AS20),
    .RW20       (RW20),
    .RAM_SEL    (RAM_SEL),
    .BANK       (BANK),
    .LANE_EN    (LANE_EN),
    .RAS        (RAS),
    .CAS        (CAS),
    .RAM_MUX    (RAM_MUX),
    .RAMOE      (RAMOE),
    .RAM_ACK    (RAM_ACK),
    .REF_BUSY   (REF_BUSY),
    .REF_OVERRUN(REF_OVERRUN)
  );

  always #5 CLKCPU = ~CLKCPU;

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkCount(input string name, input int act, input int exp);
    nCompared++;
    if (act != exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mEdges = 0; mBacklog = 0; mKind = K_IDLE; mStep = 0;
    mOverrun = 0; mPreRef = 0; mBank = 0; mRead = 1; mLanes = 4'h0;
    eRas = 2'b11; eCas = 4'hF; eMux = 1; eOe = 1; eAck = 1; eBusy = 0;
  endtask

  task automatic modelStep();
    bit req;
    bit grantRef;
    // Outputs show what the array was doing during the cycle that just ended.
    eRas = 2'b11; eCas = 4'hF; eMux = 1; eOe = 1; eAck = 1; eBusy = 0;
    if (mKind == K_CPU) begin
      eRas = 2'b11 & ~(2'b01 << mBank);
      eMux = (mStep == 0);
      if (mStep >= 2) begin
        eCas = ~mLanes;
        eAck = 0;
        eOe  = !mRead;
      end
    end else if (mKind == K_REF) begin
      eCas  = 4'h0;
      eBusy = 1;
      if (mStep > 0) eRas = 2'b00;
    end else if (mKind == K_PRE) begin
      eBusy = mPreRef;
    end
    mEdges++;
    req      = (mEdges % RI == 0);
    grantRef = 0;
    case (mKind)
      K_IDLE: begin
        if (mBacklog > 0) begin
          mKind = K_REF; mStep = 0; grantRef = 1;
        end else if (!AS20 && !RAM_SEL) begin
          mKind = K_CPU; mStep = 0; mBank = BANK; mLanes = LANE_EN; mRead = RW20;
        end
      end
      K_CPU: begin
        if (AS20) begin
          mKind = K_PRE; mStep = 0; mPreRef = 0;
        end else if (mStep < 2) begin
          mStep++;
        end
      end
      K_REF: begin
        if (mStep == RR) begin
          mKind = K_PRE; mStep = 0; mPreRef = 1;
        end else begin
          mStep++;
        end
      end
      default: begin
        mStep++;
        if (mStep == PC) mKind = K_IDLE;
      end
    endcase
    if (req) begin
      if (mBacklog == BM) mOverrun = 1;
      else                mBacklog++;
    end
    if (grantRef) mBacklog--;
  endtask

  // Every cycle (and on any reset assertion) the DUT outputs are compared to the model.
  always @(posedge CLKCPU or negedge RESET) begin
    if (!RESET) modelReset();
    else        modelStep();
    #1;
    checkOutput("RAS", RAS, eRas);
    checkOutput("CAS", CAS, eCas);
    checkOutput("RAM_MUX", RAM_MUX, eMux);
    checkOutput("RAMOE", RAMOE, eOe);
    checkOutput("RAM_ACK", RAM_ACK, eAck);
    checkOutput("REF_BUSY", REF_BUSY, eBusy);
    checkOutput("REF_OVERRUN", REF_OVERRUN, mOverrun);
  end

  task automatic waitEdge();
    @(posedge CLKCPU);
    #1;
  endtask

  task automatic doReset();
    #2;
    RESET = 0; AS20 = 1; RAM_SEL = 1;
    repeat (5) @(posedge CLKCPU);
    #1;
    RESET = 1;
  endtask

  task automatic request(input logic bank, input logic [3:0] lanes, input logic rw);
    AS20 = 0; RAM_SEL = 0; BANK = bank; LANE_EN = lanes; RW20 = rw;
  endtask

  task automatic applyStimulus(input int nTrans);
    for (int t = 0; t < nTrans; t++) begin
      int gap;
      int hold;
      gap = $urandom_range(0, 6);
      for (int g = 0; g < gap; g++) begin
        BANK = 1'($urandom); LANE_EN = 4'($urandom); RW20 = 1'($urandom);
        RAM_SEL = 1'($urandom);
        waitEdge();
      end
      request(1'($urandom), 4'($urandom), 1'($urandom));
      RAM_SEL = ($urandom_range(0, 7) == 0);
      hold = ($urandom_range(0, 15) == 0) ? $urandom_range(40, 90) : $urandom_range(1, 10);
      for (int h = 0; h < hold; h++) begin
        waitEdge();
        BANK = 1'($urandom); LANE_EN = 4'($urandom); RW20 = 1'($urandom);
      end
      AS20 = 1; RAM_SEL = 1;
      waitEdge();
    end
  endtask

  initial begin
    int k;
    int busyCnt;
    int refCnt;
    bit ackSeen;

    // Reset state
    doReset();
    checkOutput("rst_RAS", RAS, 4'h3);
    checkOutput("rst_CAS", CAS, 4'hF);
    checkOutput("rst_MUX", RAM_MUX, 1);
    checkOutput("rst_OE", RAMOE, 1);
    checkOutput("rst_ACK", RAM_ACK, 1);
    checkOutput("rst_OVR", REF_OVERRUN, 0);

    // Idle refresh: request at edge 20, CAS-only frame at edge 22
    repeat (22) waitEdge();
    checkOutput("ref_cas_CAS", CAS, 4'h0);
    checkOutput("ref_cas_RAS", RAS, 4'h3);
    busyCnt = REF_BUSY ? 1 : 0;
    waitEdge();
    checkOutput("ref_ras_RAS", RAS, 4'h0);
    if (REF_BUSY) busyCnt++;
    repeat (7) begin
      waitEdge();
      if (REF_BUSY) busyCnt++;
    end
    checkCount("ref_busy_cycles", busyCnt, 6);

    // Longword read from bank 1, then a byte write to bank 0
    doReset();
    request(1, 4'hF, 1);
    waitEdge();
    waitEdge();
    checkOutput("rd_row_RAS", RAS, 4'h1);
    checkOutput("rd_row_MUX", RAM_MUX, 1);
    waitEdge();
    checkOutput("rd_col_MUX", RAM_MUX, 0);
    checkOutput("rd_col_CAS", CAS, 4'hF);
    waitEdge();
    checkOutput("rd_CAS", CAS, 4'h0);
    checkOutput("rd_OE", RAMOE, 0);
    checkOutput("rd_ACK", RAM_ACK, 0);
    repeat (2) waitEdge();
    AS20 = 1; RAM_SEL = 1;
    repeat (2) waitEdge();
    checkOutput("rd_pre_ACK", RAM_ACK, 1);
    checkOutput("rd_pre_RAS", RAS, 4'h3);
    waitEdge();
    request(0, 4'b0100, 0);
    repeat (4) waitEdge();
    checkOutput("wr_RAS", RAS, 4'h2);
    checkOutput("wr_CAS", CAS, 4'b1011);
    checkOutput("wr_OE", RAMOE, 1);
    checkOutput("wr_ACK", RAM_ACK, 0);
    AS20 = 1; RAM_SEL = 1;
    repeat (2) waitEdge();
    checkOutput("wr_end_ACK", RAM_ACK, 1);

    // Abort while in COL: no CAS and no acknowledge ever
    doReset();
    request(1, 4'hF, 1);
    repeat (2) waitEdge();
    AS20 = 1; RAM_SEL = 1;
    ackSeen = 0;
    repeat (6) begin
      waitEdge();
      if (RAM_ACK == 0 || CAS != 4'hF) ackSeen = 1;
    end
    checkOutput("abort_no_strobe", ackSeen, 0);

    // Collision: CPU request first seen while the backlog is 1
    doReset();
    repeat (20) waitEdge();
    request(0, 4'b0011, 1);
    repeat (10) waitEdge();
    checkOutput("coll_ACK_wait", RAM_ACK, 1);
    waitEdge();
    checkOutput("coll_ACK", RAM_ACK, 0);
    AS20 = 1; RAM_SEL = 1;
    repeat (4) waitEdge();

    // Overrun: hold a RAM cycle until the backlog saturates, then drain
    doReset();
    request(0, 4'hF, 1);
    k = 0;
    do begin
      waitEdge();
      k++;
    end while (!REF_OVERRUN && k < 200);
    checkOutput("ovr_set", REF_OVERRUN, 1);
    checkCount("ovr_edge", k, 4 * RI);
    AS20 = 1; RAM_SEL = 1;
    refCnt = 0;
    repeat (24) begin
      waitEdge();
      if (CAS == 4'h0 && RAS == 2'b11) refCnt++;
    end
    checkCount("ovr_refreshes", refCnt, 3);
    checkOutput("ovr_sticky", REF_OVERRUN, 1);

    // Reset asserted during STROBE takes effect immediately
    doReset();
    request(1, 4'hF, 0);
    repeat (4) waitEdge();
    #2;
    RESET = 0;
    #1;
    checkOutput("async_ACK", RAM_ACK, 1);
    checkOutput("async_CAS", CAS, 4'hF);
    checkOutput("async_RAS", RAS, 4'h3);
    AS20 = 1; RAM_SEL = 1;
    repeat (3) @(posedge CLKCPU);
    #1;
    RESET = 1;

    applyStimulus(300);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
